reorder_buffer: RTL and testbench

In-order retirement queue for the out-of-order MIPS core. Dispatch allocates one entry per instruction and stores the entry tag in the register status table. Execution units complete entries over the common data bus (CDB). The head entry retires once done, driving the commit write into the register file and register status table, and a mispredicted branch at the head flushes the machine.

---
 rtl/reorder_buffer.sv | 121 ++++++++++++
 tb/tb_reorder_buffer.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/reorder_buffer.sv
// rtl/reorder_buffer.sv - in-order retirement queue with CDB completion, commit and flush (optional ROB_BYPASS_EN read bypass)
module reorder_buffer #(
    parameter int TAG_W  = 4,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alloc_en,
    input  logic              alloc_has_dest,
    input  logic [4:0]        alloc_dest_reg,
    output logic [TAG_W-1:0]  alloc_rb_tag,
    output logic              full,
    output logic              empty,
    output logic [TAG_W:0]    count,
    input  logic              cdb_en,
    input  logic [TAG_W-1:0]  cdb_rb_tag,
    input  logic [DATA_W-1:0] cdb_value,
    input  logic              cdb_mispredict,
    input  logic [TAG_W-1:0]  rd_rb_tag1,
    input  logic [TAG_W-1:0]  rd_rb_tag2,
    output logic              rd_ready1,
    output logic              rd_ready2,
    output logic [DATA_W-1:0] rd_value1,
    output logic [DATA_W-1:0] rd_value2,
    output logic              retire_en,
    output logic              commit_en,
    output logic [4:0]        commit_reg_tag,
    output logic [TAG_W-1:0]  commit_rb_tag,
    output logic [DATA_W-1:0] commit_value,
    output logic              flush_regs
);
    localparam int DEPTH = 1 << TAG_W;
    localparam logic [TAG_W:0] DEPTH_C = (TAG_W+1)'(DEPTH);

    logic [DEPTH-1:0]  valid;
    logic [DEPTH-1:0]  done;
    logic [DEPTH-1:0]  has_dest;
    logic [DEPTH-1:0]  mispredict;
    logic [4:0]        dest_reg [DEPTH];
    logic [DATA_W-1:0] value    [DEPTH];
    logic [TAG_W-1:0]  head;
    logic [TAG_W-1:0]  tail;
    logic [TAG_W:0]    count_q;
    logic              do_alloc;
    logic              cdb_hit;

    // full is taken from the pre-retire count, so a full buffer refuses alloc even while retiring
    assign full         = (count_q == DEPTH_C);
    assign empty        = (count_q == '0);
    assign count        = count_q;
    assign alloc_rb_tag = tail;
    assign do_alloc     = alloc_en && !full;
    assign cdb_hit      = cdb_en && valid[cdb_rb_tag];

    // retirement only looks at stored head state; same-cycle CDB data is never seen here
    assign retire_en      = valid[head] && done[head] && !mispredict[head];
    assign flush_regs     = valid[head] && done[head] && mispredict[head];
    assign commit_en      = retire_en && has_dest[head];
    assign commit_reg_tag = dest_reg[head];
    assign commit_rb_tag  = head;
    assign commit_value   = value[head];

`ifdef ROB_BYPASS_EN
    // operand lookup with forwarding of a same-cycle broadcast to a live entry
    assign rd_ready1 = (valid[rd_rb_tag1] && done[rd_rb_tag1]) || (cdb_hit && cdb_rb_tag == rd_rb_tag1);
    assign rd_ready2 = (valid[rd_rb_tag2] && done[rd_rb_tag2]) || (cdb_hit && cdb_rb_tag == rd_rb_tag2);
    assign rd_value1 = (cdb_hit && cdb_rb_tag == rd_rb_tag1) ? cdb_value : value[rd_rb_tag1];
    assign rd_value2 = (cdb_hit && cdb_rb_tag == rd_rb_tag2) ? cdb_value : value[rd_rb_tag2];
`else
    // operand lookup from stored state only
    assign rd_ready1 = valid[rd_rb_tag1] && done[rd_rb_tag1];
    assign rd_ready2 = valid[rd_rb_tag2] && done[rd_rb_tag2];
    assign rd_value1 = value[rd_rb_tag1];
    assign rd_value2 = value[rd_rb_tag2];
`endif

    // entry table and pointer update: reset, then flush, then alloc/complete/retire together
    always_ff @(posedge clk) begin
        if (rst) begin
            valid      <= '0;
            done       <= '0;
            has_dest   <= '0;
            mispredict <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                dest_reg[i] <= '0;
                value[i]    <= '0;
            end
            head    <= '0;
            tail    <= '0;
            count_q <= '0;
        end else if (flush_regs) begin
            valid   <= '0;
            head    <= '0;
            tail    <= '0;
            count_q <= '0;
        end else begin
            if (do_alloc) begin
                valid[tail]      <= 1'b1;
                done[tail]       <= 1'b0;
                mispredict[tail] <= 1'b0;
                has_dest[tail]   <= alloc_has_dest;
                dest_reg[tail]   <= alloc_dest_reg;
                tail             <= tail + TAG_W'(1);
            end
            if (cdb_hit) begin
                done[cdb_rb_tag]       <= 1'b1;
                value[cdb_rb_tag]      <= cdb_value;
                mispredict[cdb_rb_tag] <= cdb_mispredict;
            end
            if (retire_en) begin
                valid[head] <= 1'b0;
                head        <= head + TAG_W'(1);
            end
            if (do_alloc && !retire_en) begin
                count_q <= count_q + (TAG_W+1)'(1);
            end else if (!do_alloc && retire_en) begin
                count_q <= count_q - (TAG_W+1)'(1);
            end
        end
    end
endmodule

// File: tb/tb_reorder_buffer.sv
// tb/tb_reorder_buffer.sv - directed self-checking bench for reorder_buffer
module tb_reorder_buffer;
    logic        clk = 1'b0;
    logic        rst;
    logic        alloc_en;
    logic        alloc_has_dest;
    logic [4:0]  alloc_dest_reg;
    logic [3:0]  alloc_rb_tag;
    logic        full;
    logic        empty;
    logic [4:0]  count;
    logic        cdb_en;
    logic [3:0]  cdb_rb_tag;
    logic [31:0] cdb_value;
    logic        cdb_mispredict;
    logic [3:0]  rd_rb_tag1;
    logic [3:0]  rd_rb_tag2;
    logic        rd_ready1;
    logic        rd_ready2;
    logic [31:0] rd_value1;
    logic [31:0] rd_value2;
    logic        retire_en;
    logic        commit_en;
    logic [4:0]  commit_reg_tag;
    logic [3:0]  commit_rb_tag;
    logic [31:0] commit_value;
    logic        flush_regs;

    int checks = 0;
    int errors = 0;

    reorder_buffer #(.TAG_W(4), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .alloc_en(alloc_en), .alloc_has_dest(alloc_has_dest), .alloc_dest_reg(alloc_dest_reg),
        .alloc_rb_tag(alloc_rb_tag), .full(full), .empty(empty), .count(count),
        .cdb_en(cdb_en), .cdb_rb_tag(cdb_rb_tag), .cdb_value(cdb_value), .cdb_mispredict(cdb_mispredict),
        .rd_rb_tag1(rd_rb_tag1), .rd_rb_tag2(rd_rb_tag2),
        .rd_ready1(rd_ready1), .rd_ready2(rd_ready2), .rd_value1(rd_value1), .rd_value2(rd_value2),
        .retire_en(retire_en), .commit_en(commit_en), .commit_reg_tag(commit_reg_tag),
        .commit_rb_tag(commit_rb_tag), .commit_value(commit_value), .flush_regs(flush_regs)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        alloc_en = 1'b0; cdb_en = 1'b0;
        step();
        rst = 1'b0;
    endtask

    task automatic fill(input int n);
        for (int i = 0; i < n; i++) begin
            alloc_en = 1'b1; alloc_has_dest = 1'b1; alloc_dest_reg = 5'(i + 1);
            step();
        end
        alloc_en = 1'b0;
    endtask

    task automatic cdb(input logic [3:0] tag, input logic [31:0] val, input logic misp);
        cdb_en = 1'b1; cdb_rb_tag = tag; cdb_value = val; cdb_mispredict = misp;
    endtask

    initial begin
        logic exp_byp;
`ifdef ROB_BYPASS_EN
        exp_byp = 1'b1;
`else
        exp_byp = 1'b0;
`endif
        rst = 1'b1; alloc_en = 1'b0; alloc_has_dest = 1'b0; alloc_dest_reg = '0;
        cdb_en = 1'b0; cdb_rb_tag = '0; cdb_value = '0; cdb_mispredict = 1'b0;
        rd_rb_tag1 = '0; rd_rb_tag2 = '0;
        step(); step();
        rst = 1'b0;
        settle();
        check("rst_count", count, 0);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_tag", alloc_rb_tag, 0);
        check("rst_retire", retire_en, 0);
        check("rst_commit", commit_en, 0);
        check("rst_flush", flush_regs, 0);
        check("rst_creg", commit_reg_tag, 0);
        check("rst_cval", commit_value, 0);
        check("rst_rdy1", rd_ready1, 0);
        check("rst_rval1", rd_value1, 0);

        // fill all 16 entries, then a rejected 17th
        for (int i = 0; i < 16; i++) begin
            alloc_en = 1'b1; alloc_has_dest = 1'b1; alloc_dest_reg = 5'(i + 1);
            settle();
            check($sformatf("fill_tag%0d", i), alloc_rb_tag, i);
            step();
        end
        alloc_en = 1'b0;
        check("fill_full", full, 1);
        check("fill_count", count, 16);
        check("fill_empty", empty, 0);
        alloc_en = 1'b1; alloc_dest_reg = 5'd17;
        step();
        alloc_en = 1'b0;
        check("over_count", count, 16);
        check("over_tail", alloc_rb_tag, 0);

        // out-of-order completion, in-order retirement
        do_reset();
        fill(2);
        cdb(4'd1, 32'hBEEF, 1'b0);
        step();
        cdb(4'd0, 32'h1234, 1'b0);
        settle();
        check("ooo_noret", retire_en, 0);
        step();
        cdb_en = 1'b0;
        settle();
        check("ret0_en", retire_en, 1);
        check("ret0_commit", commit_en, 1);
        check("ret0_reg", commit_reg_tag, 1);
        check("ret0_tag", commit_rb_tag, 0);
        check("ret0_val", commit_value, 32'h1234);
        step();
        check("ret1_commit", commit_en, 1);
        check("ret1_reg", commit_reg_tag, 2);
        check("ret1_tag", commit_rb_tag, 1);
        check("ret1_val", commit_value, 32'hBEEF);
        step();
        check("ret_empty", empty, 1);
        check("ret_retire", retire_en, 0);

        // mispredicted branch at head flushes
        do_reset();
        alloc_en = 1'b1; alloc_has_dest = 1'b0; alloc_dest_reg = 5'd0;
        step();
        fill(3);
        cdb(4'd0, 32'h0, 1'b1);
        step();
        cdb(4'd2, 32'h77, 1'b0);
        alloc_en = 1'b1; alloc_has_dest = 1'b1; alloc_dest_reg = 5'd9;
        settle();
        check("fl_flush", flush_regs, 1);
        check("fl_retire", retire_en, 0);
        check("fl_commit", commit_en, 0);
        step();
        alloc_en = 1'b0; cdb_en = 1'b0;
        settle();
        check("fl_flush_off", flush_regs, 0);
        check("fl_count", count, 0);
        check("fl_empty", empty, 1);
        check("fl_tag", alloc_rb_tag, 0);

        // full buffer retires while dispatch pushes: reject, then accept at wrapped tail
        do_reset();
        fill(16);
        cdb(4'd0, 32'h55, 1'b0);
        step();
        cdb_en = 1'b0;
        alloc_en = 1'b1; alloc_has_dest = 1'b1; alloc_dest_reg = 5'd20;
        settle();
        check("wr_retire", retire_en, 1);
        check("wr_full", full, 1);
        check("wr_cval", commit_value, 32'h55);
        step();
        check("wr_count15", count, 15);
        check("wr_full0", full, 0);
        check("wr_tag0", alloc_rb_tag, 0);
        step();
        alloc_en = 1'b0;
        settle();
        check("wr_count16", count, 16);
        check("wr_tag1", alloc_rb_tag, 1);
        rd_rb_tag1 = 4'd0;
        settle();
        check("wr_rdy0", rd_ready1, 0);

        // read port visibility of a completion
        do_reset();
        fill(6);
        rd_rb_tag1 = 4'd5; rd_rb_tag2 = 4'd3;
        cdb(4'd5, 32'hCAFE, 1'b0);
        settle();
        check("byp_rdy", rd_ready1, exp_byp);
        check("byp_val", rd_value1, exp_byp ? 32'hCAFE : 32'h0);
        check("byp_rdy2", rd_ready2, 0);
        step();
        cdb_en = 1'b0;
        settle();
        check("rd_rdy", rd_ready1, 1);
        check("rd_val", rd_value1, 32'hCAFE);
        check("rd_head_wait", retire_en, 0);

        // reset mid-stream, then a stale CDB
        do_reset();
        fill(7);
        check("mid_count7", count, 7);
        rst = 1'b1;
        step();
        rst = 1'b0;
        settle();
        check("mid_count", count, 0);
        check("mid_empty", empty, 1);
        check("mid_full", full, 0);
        check("mid_tag", alloc_rb_tag, 0);
        check("mid_retire", retire_en, 0);
        check("mid_commit", commit_en, 0);
        check("mid_flush", flush_regs, 0);
        check("mid_cval", commit_value, 0);
        rd_rb_tag2 = 4'd3;
        cdb(4'd3, 32'h99, 1'b0);
        step();
        cdb_en = 1'b0;
        settle();
        check("stale_rdy", rd_ready2, 0);
        check("stale_count", count, 0);
        check("stale_retire", retire_en, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
